// File: rtl/uart_frame_assembler.sv
// UART frame assembler: hunts for a sync byte, then gathers a checksummed payload into a 66-bit command.
// The command is held on uart_in until done; malformed or stalled frames are dropped and counted.
module uart_frame_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TMO_W          = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        done,
    output logic [65:0] uart_in,
    output logic        uart_ready,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic [1:0]  st
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        HOLD    = 2'd2,
        SPARE   = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [7:0]       pay [9];
    logic [7:0]       ck;
    logic [3:0]       idx;
    logic [TMO_W-1:0] tmo;

    logic is_sync;
    logic ck_pop;
    logic frame_ok;
    logic tmo_hit;
    logic drop;

    always_comb begin
        is_sync  = rd_uart && (r_data == SYNC_BYTE);
        ck_pop   = rd_uart && (state == PAYLOAD) && (idx == 4'd9);
        frame_ok = ck_pop && (r_data == ck) && (pay[0][7:2] == 6'd0);
        tmo_hit  = (state == PAYLOAD) && !rd_uart && (tmo == TMO_LAST);
        drop     = (ck_pop && !frame_ok) || tmo_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            HUNT: begin
                if (is_sync) begin
                    state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (frame_ok) begin
                    state_n = HOLD;
                end else if (drop) begin
                    state_n = HUNT;
                end
            end
            HOLD: begin
                if (done) begin
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_comb begin
        rd_uart = !rx_empty && ((state == HUNT) || (state == PAYLOAD));
        st      = state;
    end

    // A sync value seen while in PAYLOAD is ordinary data; only HUNT restarts a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= 4'd0;
            ck  <= 8'd0;
            tmo <= '0;
            for (int i = 0; i < 9; i++) begin
                pay[i] <= 8'd0;
            end
        end else if (state == HUNT) begin
            if (is_sync) begin
                idx <= 4'd0;
                ck  <= 8'd0;
                tmo <= '0;
            end
        end else if (state == PAYLOAD) begin
            if (rd_uart) begin
                tmo <= '0;
                if (idx != 4'd9) begin
                    for (int i = 0; i < 9; i++) begin
                        if (idx == 4'(i)) begin
                            pay[i] <= r_data;
                        end
                    end
                    ck  <= ck ^ r_data;
                    idx <= idx + 4'd1;
                end
            end else if (!tmo_hit) begin
                tmo <= tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_in    <= '0;
            uart_ready <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            frame_err <= drop;
            if (drop && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (frame_ok) begin
                uart_in    <= {pay[0][1:0], pay[1], pay[2], pay[3], pay[4],
                               pay[5], pay[6], pay[7], pay[8]};
                uart_ready <= 1'b1;
            end else if ((state == HOLD) && done) begin
                uart_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: a queue stands in for the RX FIFO,
// and expected commands/errors come from frames built by the bench itself.
module tb_uart_frame_assembler;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'd0;
    logic        rd_uart;
    logic        done = 1'b0;
    logic [65:0] uart_in;
    logic        uart_ready;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [1:0]  st;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int exp_err = 0;

    logic [7:0] fifo [$];

    uart_frame_assembler #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO),
        .TMO_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_empty(rx_empty),
        .r_data(r_data),
        .rd_uart(rd_uart),
        .done(done),
        .uart_in(uart_in),
        .uart_ready(uart_ready),
        .frame_err(frame_err),
        .err_count(err_count),
        .st(st)
    );

    always #5 clk = ~clk;

    function automatic void refresh();
        rx_empty = (fifo.size() == 0);
        r_data = (fifo.size() != 0) ? fifo[0] : 8'd0;
    endfunction

    always @(posedge clk) begin
        bit p;
        p = rd_uart && !rx_empty;
        #1;
        if (p && fifo.size() != 0) void'(fifo.pop_front());
        refresh();
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    function automatic void bump_err();
        if (exp_err < 255) exp_err++;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic push_frame(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [5:0] hi,
                              input logic [7:0] ckx, output logic [65:0] cmd);
        logic [7:0] p [9];
        logic [7:0] ck;
        p[0] = {hi, op};
        for (int k = 1; k <= 4; k++) p[k] = a[8*(4-k) +: 8];
        for (int k = 5; k <= 8; k++) p[k] = b[8*(8-k) +: 8];
        ck = 8'd0;
        fifo.push_back(8'hA5);
        for (int k = 0; k < 9; k++) begin
            ck ^= p[k];
            fifo.push_back(p[k]);
        end
        fifo.push_back(ck ^ ckx);
        refresh();
        cmd = {op, a, b};
    endtask

    task automatic wait_ready(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (uart_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_ready, frame_err, st, rd_uart} !== 5'd0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000", {uart_ready, frame_err, st, rd_uart});
        end
        checks++;
        if (uart_in !== 66'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 0/0", uart_in, err_count);
        end
        reset = 1'b1;
        exp_err = 0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [65:0] cmd;
        logic [65:0] held;
        push_frame(2'd0, 32'h3F800000, 32'h40000000, 6'd0, 8'd0, cmd);
        repeat (10) @(negedge clk);
        checks++;
        if (uart_ready !== 1'b0) begin
            errors++;
            $display("FAIL good_early: got ready=%b want 0", uart_ready);
        end
        @(negedge clk);
        checks++;
        if (uart_ready !== 1'b1 || st !== 2'd2) begin
            errors++;
            $display("FAIL good_latency: got ready=%b st=%0d want 1/2", uart_ready, st);
        end
        checks++;
        if (uart_in !== 66'h0_3F800000_40000000) begin
            errors++;
            $display("FAIL good_cmd: got %h want %h", uart_in, 66'h0_3F800000_40000000);
        end
        held = uart_in;
        repeat (5) @(negedge clk);
        checks++;
        if (uart_ready !== 1'b1 || uart_in !== held || err_count !== 8'd0) begin
            errors++;
            $display("FAIL good_hold: got ready=%b cmd=%h err=%0d", uart_ready, uart_in, err_count);
        end
        pulse_done();
        checks++;
        if (uart_ready !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL good_release: got ready=%b st=%0d want 0/0", uart_ready, st);
        end
    endtask

    task automatic test_bad_checksum();
        logic [65:0] cmd;
        int p0;
        bit ok;
        p0 = err_pulses;
        push_frame(2'd0, 32'h3F800000, 32'h40000000, 6'd0, 8'h01, cmd);
        repeat (14) @(negedge clk);
        bump_err();
        checks++;
        if (err_pulses - p0 !== 1 || err_count !== 8'(exp_err) || uart_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_ck: got pulses=%0d cnt=%0d ready=%b want 1/%0d/0",
                     err_pulses - p0, err_count, uart_ready, exp_err);
        end
        push_frame(2'd2, 32'h12345678, 32'h9ABCDEF0, 6'd0, 8'd0, cmd);
        wait_ready(40, ok);
        checks++;
        if (!ok || uart_in !== cmd) begin
            errors++;
            $display("FAIL bad_ck_recover: got ok=%b cmd=%h want %h", ok, uart_in, cmd);
        end
        pulse_done();
    endtask

    task automatic test_noise();
        logic [65:0] cmd;
        int p0;
        bit ok;
        p0 = err_pulses;
        push_byte(8'h11);
        push_byte(8'h22);
        push_frame(2'd1, 32'hDEADBEEF, 32'h00000001, 6'd0, 8'd0, cmd);
        wait_ready(40, ok);
        checks++;
        if (!ok || uart_in !== cmd) begin
            errors++;
            $display("FAIL noise_cmd: got ok=%b cmd=%h want %h", ok, uart_in, cmd);
        end
        checks++;
        if (err_pulses !== p0 || err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL noise_err: got pulses=%0d cnt=%0d want %0d/%0d",
                     err_pulses, err_count, p0, exp_err);
        end
        pulse_done();
    endtask

    task automatic test_timeout();
        logic [65:0] cmd;
        int p0;
        bit ok;
        p0 = err_pulses;
        push_byte(8'hA5);
        for (int k = 0; k < 5; k++) push_byte(8'($urandom_range(0, 255)) & 8'h03);
        repeat (6 + TMO - 2) @(negedge clk);
        checks++;
        if (st !== 2'd1 || err_pulses !== p0) begin
            errors++;
            $display("FAIL tmo_early: got st=%0d pulses=%0d want 1/%0d", st, err_pulses - p0, 0);
        end
        repeat (3) @(negedge clk);
        bump_err();
        checks++;
        if (st !== 2'd0 || err_pulses - p0 !== 1 || err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL tmo_drop: got st=%0d pulses=%0d cnt=%0d want 0/1/%0d",
                     st, err_pulses - p0, err_count, exp_err);
        end
        push_frame(2'd3, 32'hA5A50011, 32'h00A500A5, 6'd0, 8'd0, cmd);
        wait_ready(40, ok);
        checks++;
        if (!ok || uart_in !== cmd) begin
            errors++;
            $display("FAIL tmo_no_resync: got ok=%b cmd=%h want %h", ok, uart_in, cmd);
        end
        pulse_done();
    endtask

    task automatic test_back_to_back();
        logic [65:0] c1;
        logic [65:0] c2;
        bit ok;
        push_frame(2'd1, 32'h11111111, 32'h22222222, 6'd0, 8'd0, c1);
        push_frame(2'd2, 32'h33333333, 32'h44444444, 6'd0, 8'd0, c2);
        wait_ready(40, ok);
        checks++;
        if (!ok || uart_in !== c1) begin
            errors++;
            $display("FAIL b2b_first: got ok=%b cmd=%h want %h", ok, uart_in, c1);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (fifo.size() !== 11 || rd_uart !== 1'b0 || uart_in !== c1) begin
            errors++;
            $display("FAIL b2b_backpressure: got fifo=%0d rd=%b cmd=%h want 11/0/%h",
                     fifo.size(), rd_uart, uart_in, c1);
        end
        pulse_done();
        wait_ready(40, ok);
        checks++;
        if (!ok || uart_in !== c2) begin
            errors++;
            $display("FAIL b2b_second: got ok=%b cmd=%h want %h", ok, uart_in, c2);
        end
        pulse_done();
    endtask

    task automatic test_done_same_cycle();
        logic [65:0] cmd;
        push_frame(2'd0, 32'h0000FFFF, 32'hFFFF0000, 6'd0, 8'd0, cmd);
        repeat (11) @(negedge clk);
        checks++;
        if (uart_ready !== 1'b1 || uart_in !== cmd) begin
            errors++;
            $display("FAIL done_rise: got ready=%b cmd=%h want 1/%h", uart_ready, uart_in, cmd);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        checks++;
        if (uart_ready !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL done_immediate: got ready=%b st=%0d want 0/0", uart_ready, st);
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0] cmd;
        bit ok;
        push_byte(8'hA5);
        push_byte(8'h01);
        push_byte(8'h02);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (st !== 2'd0 || uart_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_payload: got st=%0d ready=%b want 0/0", st, uart_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_err = 0;
        push_frame(2'd1, 32'hCAFEF00D, 32'h0BADBEEF, 6'd0, 8'd0, cmd);
        wait_ready(40, ok);
        checks++;
        if (!ok || uart_in !== cmd || err_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_after_payload: got ok=%b cmd=%h cnt=%0d", ok, uart_in, err_count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (uart_ready !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL rst_hold: got ready=%b st=%0d want 0/0", uart_ready, st);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (err_count !== 8'd0 || uart_ready !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL rst_release: got cnt=%0d ready=%b st=%0d want 0/0/0",
                     err_count, uart_ready, st);
        end
    endtask

    task automatic test_random();
        logic [65:0] exp_q [$];
        logic [65:0] cmd;
        logic [65:0] want;
        int bad = 0;
        int p0;
        int kind;
        bit ok;
        p0 = err_pulses;
        for (int f = 0; f < 24; f++) begin
            int nn;
            nn = $urandom_range(0, 3);
            for (int n = 0; n < nn; n++) begin
                logic [7:0] z;
                z = 8'($urandom_range(0, 255));
                if (z == 8'hA5) z = 8'h5A;
                push_byte(z);
            end
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                push_frame(2'($urandom), $urandom, $urandom, 6'd0,
                           8'($urandom_range(1, 255)), cmd);
                bad++;
                bump_err();
            end else if (kind == 1) begin
                push_frame(2'($urandom), $urandom, $urandom,
                           6'($urandom_range(1, 63)), 8'd0, cmd);
                bad++;
                bump_err();
            end else begin
                push_frame(2'($urandom), $urandom, $urandom, 6'd0, 8'd0, cmd);
                exp_q.push_back(cmd);
            end
        end
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            wait_ready(1000, ok);
            checks++;
            if (!ok || uart_in !== want) begin
                errors++;
                $display("FAIL rand_cmd: got ok=%b cmd=%h want %h", ok, uart_in, want);
            end
            pulse_done();
        end
        for (int i = 0; i < 1000 && fifo.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (err_pulses - p0 !== bad || err_count !== 8'(exp_err) || uart_ready !== 1'b0) begin
            errors++;
            $display("FAIL rand_err: got pulses=%0d cnt=%0d ready=%b want %0d/%0d/0",
                     err_pulses - p0, err_count, uart_ready, bad, exp_err);
        end
    endtask

    initial begin
        refresh();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_noise();
        test_timeout();
        test_back_to_back();
        test_done_same_cycle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
